// File: rtl/memory_responder.sv
// memory_responder: fixed-latency word memory answering datapath MAR/MDR read and write requests
module memory_responder #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] MARaddr,
  input  logic [31:0] MDRdata,
  input  logic        Read,
  input  logic        Write,
  output logic [31:0] Mdatain,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] addr, data;
  logic rd, wr, perr;
  logic [31:0] mem [DEPTH];
  logic in_range, fin;
  logic [ADDR_W-1:0] idx;
  assign in_range = addr[31:ADDR_W] == '0;
  assign idx = addr[ADDR_W-1:0];
  assign fin = state == WAIT && cnt == '0;
  // storage is never reset; a write lands on the WAIT->DONE edge only when in range and not a protocol error
  always_ff @(posedge clk)
    if (fin && wr && in_range) mem[idx] <= data;
  // request FSM with registered status outputs and read data
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      Mdatain <= '0;
      addr    <= '0;
      data    <= '0;
      rd      <= 1'b0;
      wr      <= 1'b0;
      perr    <= 1'b0;
    end else
      case (state)
        IDLE:
          if (Read || Write) begin
            state <= WAIT;
            cnt   <= 4'(WAIT_CYCLES - 1);
            addr  <= MARaddr;
            data  <= MDRdata;
            rd    <= Read && !Write;
            wr    <= Write && !Read;
            perr  <= Read && Write;
            busy  <= 1'b1;
          end
        WAIT:
          if (cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= perr || !in_range;
            if (rd) Mdatain <= in_range ? mem[idx] : '0;
          end else cnt <= cnt - 4'd1;
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed and random requests checked against a transaction-level model
module tb_memory_responder;
  localparam int W = 2;
  logic clk = 0, clr = 0, Read = 0, Write = 0;
  logic [31:0] MARaddr = 0, MDRdata = 0;
  logic [31:0] Mdatain;
  logic busy, done, err;
  int nchk = 0, nerr = 0;
  memory_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(W)) dut (
    .clk(clk), .clr(clr), .MARaddr(MARaddr), .MDRdata(MDRdata), .Read(Read), .Write(Write),
    .Mdatain(Mdatain), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  logic [31:0] mem_m [512];
  logic [31:0] m_mdat = 0;
  logic [31:0] q_a = 0, q_d = 0;
  bit act = 0, q_r = 0, q_w = 0, q_perr = 0, q_inr = 0, m_err = 0, e_done;
  int cyc = 0, t0 = 0;
  // an accepted request at edge t0 completes at edge t0+W and frees the block one edge later
  always @(posedge clk) begin
    cyc++;
    if (clr) begin
      act = 0;
      m_mdat = 0;
    end else if (act) begin
      if (cyc == t0 + W) begin
        q_perr = q_r && q_w;
        q_inr = q_a < 512;
        m_err = q_perr || !q_inr;
        if (!q_perr && q_w && q_inr) mem_m[q_a[8:0]] = q_d;
        if (!q_perr && q_r) m_mdat = q_inr ? mem_m[q_a[8:0]] : 32'h0;
      end else if (cyc > t0 + W) act = 0;
    end else if (Read || Write) begin
      act = 1;
      t0 = cyc;
      q_a = MARaddr;
      q_d = MDRdata;
      q_r = Read;
      q_w = Write;
    end
    e_done = act && cyc == t0 + W;
    #1;
    chk("busy", 32'(busy), 32'(act));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_done && m_err));
    chk("Mdatain", Mdatain, m_mdat);
  end
  task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic e);
    @(negedge clk);
    Read = r;
    Write = w;
    MARaddr = a;
    MDRdata = d;
    @(negedge clk);
    Read = 0;
    Write = 0;
    MARaddr = $urandom;
    MDRdata = $urandom;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = err;
    if (!done) begin
      nchk++;
      nerr++;
      $display("FAIL timeout: done never rose for addr %h", a);
    end
  endtask
  logic [31:0] tbl [12] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7,
                            32'd511, 32'h200, 32'hFFFFFFFF, 32'h80000003};
  initial begin
    int lat, ndone;
    logic e;
    #2 clr = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mdat", Mdatain, 0);
    clr = 0;
    req(0, 1, 2, 32'h0000000A, lat, e);
    chk("w2_lat", lat, W);
    chk("w2_err", 32'(e), 0);
    req(1, 0, 2, 0, lat, e);
    chk("r2_lat", lat, W);
    chk("r2_err", 32'(e), 0);
    chk("r2_data", Mdatain, 32'h0000000A);
    req(0, 1, 3, 32'h00000014, lat, e);
    req(0, 1, 1, 32'h00000018, lat, e);
    chk("mdat_hold_over_writes", Mdatain, 32'h0000000A);
    req(1, 0, 3, 0, lat, e);
    chk("r3_data", Mdatain, 32'h00000014);
    req(1, 0, 1, 0, lat, e);
    chk("r1_data", Mdatain, 32'h00000018);
    req(0, 1, 0, 32'h00000055, lat, e);
    req(1, 0, 32'h200, 0, lat, e);
    chk("oor_read_err", 32'(e), 1);
    chk("oor_read_data", Mdatain, 0);
    req(0, 1, 32'h200, 32'h00000099, lat, e);
    chk("oor_write_err", 32'(e), 1);
    req(1, 0, 0, 0, lat, e);
    chk("addr0_intact", Mdatain, 32'h00000055);
    req(1, 1, 3, 32'hDEADBEEF, lat, e);
    chk("proto_lat", lat, W);
    chk("proto_err", 32'(e), 1);
    chk("proto_mdat", Mdatain, 32'h00000055);
    req(1, 0, 3, 0, lat, e);
    chk("proto_storage", Mdatain, 32'h00000014);
    @(negedge clk);
    Read = 1;
    MARaddr = 1;
    @(negedge clk);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) Read = 0;
      if (done) ndone++;
      @(negedge clk);
    end
    chk("ignored_read_dones", ndone, 1);
    chk("ignored_read_data", Mdatain, 32'h00000018);
    @(negedge clk);
    Write = 1;
    MARaddr = 2;
    MDRdata = 32'hFFFFFFFF;
    @(negedge clk);
    Write = 0;
    clr = 1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_mdat", Mdatain, 0);
    @(negedge clk);
    clr = 0;
    req(1, 0, 2, 0, lat, e);
    chk("abort_no_commit", Mdatain, 32'h0000000A);
    for (int a = 4; a < 9; a++) req(0, 1, tbl[a], $urandom, lat, e);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      clr = ($urandom % 64) == 0;
      Read = ($urandom % 3) == 0;
      Write = ($urandom % 3) == 0;
      MARaddr = tbl[$urandom % 12];
      MDRdata = $urandom;
    end
    @(negedge clk);
    clr = 0;
    Read = 0;
    Write = 0;
    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
